// File: rtl/id_ex_pkg.sv
// Shared widths, control-bundle layout and helpers for the ID->EX pipeline register.
package id_ex_pkg;

    localparam int unsigned PC_W_DEF    = 32;
    localparam int unsigned VAL_W_DEF   = 32;
    localparam int unsigned CMD_W_DEF   = 4;
    localparam int unsigned SHIFT_W_DEF = 12;
    localparam int unsigned IMM_W_DEF   = 24;
    localparam int unsigned DEST_W_DEF  = 4;

    // Single-bit control flags in bundle order: WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm
    localparam int unsigned FLAG_W = 6;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 b;
        logic                 s;
        logic                 imm;
        logic [CMD_W_DEF-1:0] exe_cmd;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Side-effecting flags are forced low on a bubble; imm is operand selection, not an action.
    function automatic logic [FLAG_W-1:0] gate_flags(input logic valid, input logic [FLAG_W-1:0] flags);
        return valid ? flags : {5'b0_0000, flags[0]};
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_pipe_slot.sv
// One pipeline slot: a valid bit plus a bundle register with load and clear.
module pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Clear drops the valid bit and blocks the load so a flushed bundle never lands.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i & ~clear_i;
            if (load_i && !clear_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid/ready handshake, flush, and optional skid slot
// so EX hazard stalls never reach decode combinationally.
module id_ex_pipe_reg
    import id_ex_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned VAL_W   = VAL_W_DEF,
    parameter int unsigned CMD_W   = CMD_W_DEF,
    parameter int unsigned SHIFT_W = SHIFT_W_DEF,
    parameter int unsigned IMM_W   = IMM_W_DEF,
    parameter int unsigned DEST_W  = DEST_W_DEF,
    parameter int unsigned SKID    = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               WB_EN_In,
    input  logic               MEM_R_EN_In,
    input  logic               MEM_W_EN_In,
    input  logic               B_In,
    input  logic               S_In,
    input  logic               imm_In,
    input  logic [CMD_W-1:0]   EXE_CMD_In,
    input  logic [PC_W-1:0]    PC_In,
    input  logic [VAL_W-1:0]   Val_Rn_In,
    input  logic [VAL_W-1:0]   Val_Rm_In,
    input  logic [SHIFT_W-1:0] Shift_operand_In,
    input  logic [IMM_W-1:0]   Signed_imm_24_In,
    input  logic [DEST_W-1:0]  Dest_In,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               WB_EN_Out,
    output logic               MEM_R_EN_Out,
    output logic               MEM_W_EN_Out,
    output logic               B_Out,
    output logic               S_Out,
    output logic               imm_Out,
    output logic [CMD_W-1:0]   EXE_CMD_Out,
    output logic [PC_W-1:0]    PC_Out,
    output logic [VAL_W-1:0]   Val_Rn_Out,
    output logic [VAL_W-1:0]   Val_Rm_Out,
    output logic [SHIFT_W-1:0] Shift_operand_Out,
    output logic [IMM_W-1:0]   Signed_imm_24_Out,
    output logic [DEST_W-1:0]  Dest_Out
);

    localparam int unsigned DATA_W = CMD_W + PC_W + 2 * VAL_W + SHIFT_W + IMM_W + DEST_W;
    localparam int unsigned W      = FLAG_W + DATA_W;

    logic [W-1:0] in_bundle;
    logic [W-1:0] main_d;
    logic [W-1:0] main_q;
    logic         main_v_d;
    logic         main_v_q;
    logic         main_load;
    logic         acc;
    logic         drain;

    assign in_bundle = {WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, imm_In, EXE_CMD_In,
                        PC_In, Val_Rn_In, Val_Rm_In, Shift_operand_In, Signed_imm_24_In, Dest_In};

    assign acc   = in_valid & in_ready;
    assign drain = main_v_q & out_ready;

    if (SKID != 0) begin : g_skid
        logic         skid_v_d;
        logic         skid_v_q;
        logic         skid_load;
        logic [W-1:0] skid_q;

        // Ready depends only on registered skid occupancy; reset forces it high.
        assign in_ready = ~RST | ~skid_v_q;

        always_comb begin
            main_load = 1'b0;
            main_d    = in_bundle;
            main_v_d  = main_v_q;
            skid_load = 1'b0;
            skid_v_d  = skid_v_q;
            if (skid_v_q) begin
                if (drain) begin
                    main_load = 1'b1;
                    main_d    = skid_q;
                    main_v_d  = 1'b1;
                    skid_v_d  = 1'b0;
                end
            end else if (!main_v_q || drain) begin
                main_load = acc;
                main_v_d  = acc;
            end else if (acc) begin
                skid_load = 1'b1;
                skid_v_d  = 1'b1;
            end
        end

        pipe_slot #(.W(W)) u_skid (
            .clk_i   (CLK),
            .rst_ni  (RST),
            .clear_i (flush),
            .load_i  (skid_load),
            .valid_i (skid_v_d),
            .data_i  (in_bundle),
            .valid_o (skid_v_q),
            .data_o  (skid_q)
        );
    end else begin : g_single
        assign in_ready = ~RST | ~main_v_q | out_ready;

        always_comb begin
            main_load = acc;
            main_d    = in_bundle;
            main_v_d  = acc | (main_v_q & ~out_ready);
        end
    end

    pipe_slot #(.W(W)) u_main (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .clear_i (flush),
        .load_i  (main_load),
        .valid_i (main_v_d),
        .data_i  (main_d),
        .valid_o (main_v_q),
        .data_o  (main_q)
    );

    assign out_valid = main_v_q;
    assign {WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, B_Out, S_Out, imm_Out} =
        gate_flags(main_v_q, main_q[W-1 -: FLAG_W]);
    assign {EXE_CMD_Out, PC_Out, Val_Rn_Out, Val_Rm_Out, Shift_operand_Out, Signed_imm_24_Out,
            Dest_Out} = main_q[DATA_W-1:0];

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Drives SKID=1 and SKID=0 instances with shared stimulus; each is checked against a FIFO model.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        wb, mr, mw, b, s, imm;
        logic [3:0]  cmd;
        logic [31:0] pc, rn, rm;
        logic [11:0] sh;
        logic [23:0] im;
        logic [3:0]  dest;
    } bundle_t;

    logic    CLK = 1'b0;
    logic    RST = 1'b0;
    logic    flush = 1'b0;
    logic    in_valid = 1'b0;
    logic    out_ready = 1'b0;
    bundle_t din = '0;

    logic    rdy_s, rdy_n, ov_s, ov_n;
    bundle_t o_s, o_n;

    // Model: per DUT an ordered queue of at most two accepted bundles plus the bundle last at the head.
    bundle_t     fifo [2][2];
    int unsigned cnt  [2];
    bundle_t     last [2];
    int unsigned vectors = 0;
    int unsigned errs = 0;

    always #5 CLK = ~CLK;

    id_ex_pipe_reg #(.SKID(1)) u_dut_s (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(rdy_s),
        .WB_EN_In(din.wb), .MEM_R_EN_In(din.mr), .MEM_W_EN_In(din.mw), .B_In(din.b), .S_In(din.s),
        .imm_In(din.imm), .EXE_CMD_In(din.cmd), .PC_In(din.pc), .Val_Rn_In(din.rn), .Val_Rm_In(din.rm),
        .Shift_operand_In(din.sh), .Signed_imm_24_In(din.im), .Dest_In(din.dest),
        .out_valid(ov_s), .out_ready(out_ready),
        .WB_EN_Out(o_s.wb), .MEM_R_EN_Out(o_s.mr), .MEM_W_EN_Out(o_s.mw), .B_Out(o_s.b), .S_Out(o_s.s),
        .imm_Out(o_s.imm), .EXE_CMD_Out(o_s.cmd), .PC_Out(o_s.pc), .Val_Rn_Out(o_s.rn), .Val_Rm_Out(o_s.rm),
        .Shift_operand_Out(o_s.sh), .Signed_imm_24_Out(o_s.im), .Dest_Out(o_s.dest)
    );

    id_ex_pipe_reg #(.SKID(0)) u_dut_n (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(rdy_n),
        .WB_EN_In(din.wb), .MEM_R_EN_In(din.mr), .MEM_W_EN_In(din.mw), .B_In(din.b), .S_In(din.s),
        .imm_In(din.imm), .EXE_CMD_In(din.cmd), .PC_In(din.pc), .Val_Rn_In(din.rn), .Val_Rm_In(din.rm),
        .Shift_operand_In(din.sh), .Signed_imm_24_In(din.im), .Dest_In(din.dest),
        .out_valid(ov_n), .out_ready(out_ready),
        .WB_EN_Out(o_n.wb), .MEM_R_EN_Out(o_n.mr), .MEM_W_EN_Out(o_n.mw), .B_Out(o_n.b), .S_Out(o_n.s),
        .imm_Out(o_n.imm), .EXE_CMD_Out(o_n.cmd), .PC_Out(o_n.pc), .Val_Rn_Out(o_n.rn), .Val_Rm_Out(o_n.rm),
        .Shift_operand_Out(o_n.sh), .Signed_imm_24_Out(o_n.im), .Dest_Out(o_n.dest)
    );

    function automatic bundle_t rnd_bundle();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[$bits(bundle_t)-1:0];
    endfunction

    // d = 0: two-entry skid variant; d = 1: single slot, may accept while the head leaves.
    function automatic logic exp_ready(input int d);
        if (!RST) return 1'b1;
        if (d == 0) return cnt[0] < 2;
        return (cnt[1] == 0) || out_ready;
    endfunction

    task automatic model_edge();
        logic rdy, pop, push;
        for (int d = 0; d < 2; d++) begin
            rdy  = exp_ready(d);
            pop  = (cnt[d] > 0) && out_ready;
            push = in_valid && rdy;
            if (!RST) begin
                cnt[d]  = 0;
                last[d] = '0;
            end else if (flush) begin
                cnt[d] = 0;
            end else begin
                if (pop) begin
                    fifo[d][0] = fifo[d][1];
                    cnt[d]     = cnt[d] - 1;
                end
                if (push) begin
                    fifo[d][cnt[d]] = din;
                    cnt[d]          = cnt[d] + 1;
                end
            end
            if (cnt[d] > 0) last[d] = fifo[d][0];
        end
    endtask

    task automatic check();
        bundle_t e, o;
        logic    ov, rdy, ev, er;
        for (int d = 0; d < 2; d++) begin
            o   = (d == 0) ? o_s : o_n;
            ov  = (d == 0) ? ov_s : ov_n;
            rdy = (d == 0) ? rdy_s : rdy_n;
            ev  = cnt[d] > 0;
            er  = exp_ready(d);
            e   = last[d];
            if (!ev) begin
                e.wb = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.b = 1'b0; e.s = 1'b0;
            end
            vectors++;
            assert (ov === ev) else begin
                errs++;
                $error("FAIL out_valid dut%0d t=%0t: observed %b expected %b", d, $time, ov, ev);
            end
            vectors++;
            assert (rdy === er) else begin
                errs++;
                $error("FAIL in_ready dut%0d t=%0t: observed %b expected %b", d, $time, rdy, er);
            end
            vectors++;
            assert (o === e) else begin
                errs++;
                $error("FAIL fields dut%0d t=%0t: observed %h expected %h", d, $time, o, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check();
    endtask

    initial begin
        cnt[0] = 0; cnt[1] = 0;
        last[0] = '0; last[1] = '0;

        // Reset held with a valid bundle presented
        in_valid = 1'b1; out_ready = 1'b1; din = rnd_bundle();
        tick(); tick();
        RST = 1'b1;

        // Streaming PC 4..32
        for (int i = 1; i <= 8; i++) begin
            din = rnd_bundle(); din.pc = 32'(4 * i); in_valid = 1'b1; out_ready = 1'b1;
            tick();
        end

        // Three-cycle stall mid-stream
        for (int i = 0; i < 8; i++) begin
            din = rnd_bundle(); din.pc = 32'(32'h10 + 4 * i); in_valid = 1'b1;
            out_ready = !(i >= 1 && i <= 3);
            tick();
        end

        // Flush with both slots occupied and a bundle arriving
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din = rnd_bundle(); din.wb = 1'b1; din.mw = 1'b1; din.b = 1'b1; in_valid = 1'b1;
            tick();
        end
        din = rnd_bundle(); flush = 1'b1; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Bubble after a bundle carrying write-back and store
        din = rnd_bundle(); din.wb = 1'b1; din.mw = 1'b1; din.rn = 32'hDEAD_BEEF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; din = rnd_bundle();
        tick(); tick();

        // Reset in the middle of a stall
        out_ready = 1'b0; in_valid = 1'b1;
        din = rnd_bundle(); tick();
        din = rnd_bundle(); tick();
        RST = 1'b0; din = rnd_bundle(); tick();
        RST = 1'b1; out_ready = 1'b1; din = rnd_bundle(); tick();

        // Flush and reset together with slots full
        out_ready = 1'b0;
        din = rnd_bundle(); tick();
        din = rnd_bundle(); tick();
        RST = 1'b0; flush = 1'b1; din = rnd_bundle(); tick();
        RST = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0; tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            din       = rnd_bundle();
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 9) < 7;
            flush     = $urandom_range(0, 19) == 0;
            RST       = $urandom_range(0, 49) != 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID→EX pipeline register: successor to the PC-only ID stage register, carrying the full decoded instruction bundle (control bits, EXE command, PC, operand values, shift/immediate fields, destination) from decode to execute. It adds a valid/ready handshake, a pipeline flush, and an optional skid slot, so hazard stalls from EX never create a combinational ready path back into decode. It sits between the ID stage and the EX stage of the core.

## Interface
Parameters:
- PC_W, 32, PC width
- VAL_W, 32, Val_Rn/Val_Rm width
- CMD_W, 4, EXE_CMD width
- SHIFT_W, 12, Shift_operand width
- IMM_W, 24, Signed_imm_24 width
- DEST_W, 4, destination register index width
- SKID, 1, 1 = two-slot skid buffer, 0 = single slot

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, synchronous, active-low
- flush  in  1  discard all held entries (branch taken)
- in_valid  in  1  ID presents a bundle
- in_ready  out  1  register can accept this cycle
- WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, imm_In  in  1 each  control bits
- EXE_CMD_In  in  CMD_W  ALU command
- PC_In  in  PC_W  instruction PC+4
- Val_Rn_In, Val_Rm_In  in  VAL_W  register operands
- Shift_operand_In  in  SHIFT_W;  Signed_imm_24_In  in  IMM_W;  Dest_In  in  DEST_W
- out_valid  out  1  EX bundle valid
- out_ready  in  1  EX consumes this cycle (0 = hazard freeze)
- *_Out  out  same widths  registered copies of every *_In field

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- State: main slot (drives outputs) + skid slot (SKID=1 only), each with a valid bit.
- SKID=1: in_ready = !skid_valid (registered state only, no path from out_ready).
  - main empty or draining, skid empty: input → main.
  - main held (!out_ready), input accepted: input → skid.
  - main draining, skid full: skid → main; skid empties; in_ready was 0, no input.
- SKID=0: in_ready = !out_valid | out_ready; input → main.
- flush: both valid bits cleared next edge; same-cycle input dropped; flush overrides accept and drain.
- Control gating: WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, B_Out, S_Out forced 0 whenever out_valid = 0 (bubble is a true NOP). Data fields hold their last value when invalid.
- Order preserved: never reorders or duplicates; each accepted bundle leaves exactly once unless flushed.

## Timing
- Reset (RST = 0 at an edge): both valid bits 0, all *_Out 0, out_valid 0. in_ready reads 1 during reset; transfers while RST = 0 are ignored.
- Latency: accept at edge N → out_valid, fields at N+1.
- Throughput: 1 bundle/cycle with out_ready held high.
- SKID=1: after one stall cycle with input accepted, in_ready = 0 at the next cycle; returns to 1 the cycle after the skid drains.
- Reset mid-stall: both entries discarded, same as reset values.
- flush and RST both asserted: reset result (identical).

## Structure
- Shared package id_ex_pkg: default widths, field-width localparams, packed control-bundle typedef (WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm, EXE_CMD), NOP constant.
- Sub-module pipe_slot: one valid bit + bundle register with load and clear; instantiated once (SKID=0) or twice (SKID=1).

## Test plan
- Reset: RST = 0 for 2 cycles with in_valid = 1 → out_valid = 0, all *_Out = 0; after release, first bundle (PC_In = 0x0000_0004) appears one cycle after accept.
- Streaming: 8 bundles with PC_In = 4, 8, … 32, out_ready = 1 → outputs in order, one per cycle, no gaps.
- Stall, SKID=1: out_ready = 0 for 3 cycles mid-stream → PC 0x10 holds on output, 0x14 in skid, in_ready = 0; on release 0x10 then 0x14 emerge on consecutive cycles.
- Stall, SKID=0: same stimulus → in_ready tracks out_ready combinationally; no bundle lost or duplicated.
- Flush: flush = 1 while both slots hold and in_valid = 1 → next cycle out_valid = 0, WB_EN_Out = MEM_W_EN_Out = B_Out = 0, incoming bundle absent from output.
- Bubble gating: in_valid = 0 after a bundle with WB_EN = MEM_W_EN = 1 → control outputs read 0 once out_valid drops; Val_Rn_Out keeps 0xDEAD_BEEF.
